// File: rtl/player_pkg.sv
// Default sprite geometry and colours shared by every player instance.
package player_pkg;
  localparam int          DEF_SPR_W        = 40;
  localparam int          DEF_SPR_H        = 80;
  localparam int          DEF_LEG_H        = 20;
  localparam int          DEF_EYE_X        = 6;
  localparam int          DEF_EYE_Y        = 10;
  localparam int          DEF_EYE_SZ       = 6;
  localparam logic [11:0] DEF_BODY_COLOR   = 12'hF00;
  localparam logic [11:0] DEF_EYE_COLOR    = 12'h000;
  localparam int          DEF_ANIM_DIV     = 8;
  localparam int          DEF_BLINK_PERIOD = 180;
  localparam int          DEF_BLINK_LEN    = 6;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;
endpackage

// File: rtl/state_pkg.sv
// Player movement state shared by the control and drawing logic.
package state_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT2  = 2'd1,
    RIGHT2 = 2'd2
  } State;
endpackage

// File: rtl/vga_if.sv
// VGA timing plus pixel colour as passed between drawing stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/player_anim_ctrl.sv
// Per-frame control: vblank-edge detect, shadow position/state, walk and blink counters.
module player_anim_ctrl
  import state_pkg::*;
#(
  parameter int ANIM_DIV     = 8,
  parameter int BLINK_PERIOD = 180,
  parameter int BLINK_LEN    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vblnk,
  input  logic [11:0] i_xpos,
  input  logic [11:0] i_ypos,
  input  State        i_state,
  output logic [11:0] o_sx,
  output logic [11:0] o_sy,
  output State        o_s_state,
  output logic        o_walk_frame,
  output logic        o_blink
);
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  logic          r_vblnk_d;
  logic [11:0]   r_sx;
  logic [11:0]   r_sy;
  State          r_s_state;
  logic [AW-1:0] r_anim_cnt;
  logic          r_walk_frame;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink;
  logic          w_fe;
  logic [BW-1:0] w_blink_nxt;

  assign w_fe        = i_vblnk & ~r_vblnk_d;
  assign w_blink_nxt = (r_blink_cnt == BW'(BLINK_PERIOD - 1)) ? BW'(0) : r_blink_cnt + BW'(1);

  // Everything advances once per frame, on the rising edge of vblank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_d    <= 1'b0;
      r_sx         <= 12'd0;
      r_sy         <= 12'd0;
      r_s_state    <= IDLE;
      r_anim_cnt   <= AW'(0);
      r_walk_frame <= 1'b0;
      r_blink_cnt  <= BW'(0);
      r_blink      <= 1'b0;
    end else begin
      r_vblnk_d <= i_vblnk;
      if (w_fe) begin
        r_sx        <= i_xpos;
        r_sy        <= i_ypos;
        r_s_state   <= i_state;
        r_blink_cnt <= w_blink_nxt;
        r_blink     <= (w_blink_nxt >= BW'(BLINK_PERIOD - BLINK_LEN));
        if (i_state == IDLE) begin
          r_anim_cnt   <= AW'(0);
          r_walk_frame <= 1'b0;
        end else if (r_anim_cnt == AW'(ANIM_DIV - 1)) begin
          r_anim_cnt   <= AW'(0);
          r_walk_frame <= ~r_walk_frame;
        end else begin
          r_anim_cnt <= r_anim_cnt + AW'(1);
        end
      end
    end
  end

  assign o_sx         = r_sx;
  assign o_sy         = r_sy;
  assign o_s_state    = r_s_state;
  assign o_walk_frame = r_walk_frame;
  assign o_blink      = r_blink;
endmodule

// File: rtl/draw_player_anim.sv
// Animated player sprite overlay: two-stage pixel pipeline (hit test, then colour select).
module draw_player_anim
  import state_pkg::*, player_pkg::*;
#(
  parameter int          SPR_W        = DEF_SPR_W,
  parameter int          SPR_H        = DEF_SPR_H,
  parameter int          LEG_H        = DEF_LEG_H,
  parameter int          EYE_X        = DEF_EYE_X,
  parameter int          EYE_Y        = DEF_EYE_Y,
  parameter int          EYE_SZ       = DEF_EYE_SZ,
  parameter logic [11:0] BODY_COLOR   = DEF_BODY_COLOR,
  parameter logic [11:0] EYE_COLOR    = DEF_EYE_COLOR,
  parameter int          ANIM_DIV     = DEF_ANIM_DIV,
  parameter int          BLINK_PERIOD = DEF_BLINK_PERIOD,
  parameter int          BLINK_LEN    = DEF_BLINK_LEN
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vga_in,
  vga_if.out          vga_out,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  State        state
);
  localparam logic [11:0] L_W       = 12'(SPR_W);
  localparam logic [11:0] L_H       = 12'(SPR_H);
  localparam logic [11:0] L_BODY_H  = 12'(SPR_H - LEG_H);
  localparam logic [11:0] L_THIRD   = 12'(SPR_W / 3);
  localparam logic [11:0] L_THIRD_R = 12'(SPR_W - SPR_W / 3);
  localparam logic [11:0] L_EY0     = 12'(EYE_Y);
  localparam logic [11:0] L_EY1     = 12'(EYE_Y + EYE_SZ);
  localparam logic [11:0] L_EL0     = 12'(EYE_X);
  localparam logic [11:0] L_EL1     = 12'(EYE_X + EYE_SZ);
  localparam logic [11:0] L_ER0     = 12'(SPR_W - EYE_X - EYE_SZ);
  localparam logic [11:0] L_ER1     = 12'(SPR_W - EYE_X);

  logic [11:0] w_sx, w_sy, w_rx, w_ry;
  State        w_s_state;
  logic        w_walk_frame, w_blink;
  logic        w_in_box, w_frame1, w_outer, w_eye_row;
  logic        w_body, w_leg, w_eye_l, w_eye_r, w_eye_on;
  logic [11:0] w_rgb;
  logic        r_in_box, r_body, r_leg, r_eye_l, r_eye_r;
  vga_t        r_vga_d1;

  player_anim_ctrl #(
    .ANIM_DIV    (ANIM_DIV),
    .BLINK_PERIOD(BLINK_PERIOD),
    .BLINK_LEN   (BLINK_LEN)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .i_vblnk     (vga_in.vblnk),
    .i_xpos      (xpos),
    .i_ypos      (ypos),
    .i_state     (state),
    .o_sx        (w_sx),
    .o_sy        (w_sy),
    .o_s_state   (w_s_state),
    .o_walk_frame(w_walk_frame),
    .o_blink     (w_blink)
  );

  // Positions left of / above the sprite wrap to large values and fall outside the box.
  assign w_rx      = {1'b0, vga_in.hcount} - w_sx;
  assign w_ry      = {1'b0, vga_in.vcount} - w_sy;
  assign w_in_box  = (w_rx < L_W) && (w_ry < L_H);
  assign w_frame1  = w_walk_frame && (w_s_state != IDLE);
  assign w_outer   = (w_rx < L_THIRD) || (w_rx >= L_THIRD_R);
  assign w_eye_row = (w_ry >= L_EY0) && (w_ry < L_EY1);
  assign w_body    = w_in_box && (w_ry < L_BODY_H);
  assign w_leg     = w_in_box && (w_ry >= L_BODY_H) && (w_frame1 ? !w_outer : w_outer);
  assign w_eye_l   = w_in_box && w_eye_row && (w_rx >= L_EL0) && (w_rx < L_EL1);
  assign w_eye_r   = w_in_box && w_eye_row && (w_rx >= L_ER0) && (w_rx < L_ER1);

  // Stage 1: hit flags and the delayed input stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_box <= 1'b0;
      r_body   <= 1'b0;
      r_leg    <= 1'b0;
      r_eye_l  <= 1'b0;
      r_eye_r  <= 1'b0;
      r_vga_d1 <= '{11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0};
    end else begin
      r_in_box <= w_in_box;
      r_body   <= w_body;
      r_leg    <= w_leg;
      r_eye_l  <= w_eye_l;
      r_eye_r  <= w_eye_r;
      r_vga_d1 <= {vga_in.hcount, vga_in.vcount, vga_in.hsync, vga_in.vsync,
                   vga_in.hblnk, vga_in.vblnk, vga_in.rgb};
    end
  end

  // Stage 2 colour select; an unknown state value draws nothing.
  always_comb begin
    w_eye_on = 1'b0;
    w_rgb    = r_vga_d1.rgb;
    case (w_s_state)
      IDLE:    w_eye_on = r_eye_l || r_eye_r;
      LEFT2:   w_eye_on = r_eye_l;
      RIGHT2:  w_eye_on = r_eye_r;
      default: w_eye_on = 1'b0;
    endcase
    if (!r_in_box || !(w_s_state inside {IDLE, LEFT2, RIGHT2})) begin
      w_rgb = r_vga_d1.rgb;
    end else if (w_eye_on && !w_blink) begin
      w_rgb = EYE_COLOR;
    end else if (r_body || r_leg) begin
      w_rgb = BODY_COLOR;
    end else begin
      w_rgb = r_vga_d1.rgb;
    end
  end

  // Stage 2 output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.hcount <= 11'd0;
      vga_out.vcount <= 11'd0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= 12'd0;
    end else begin
      vga_out.hcount <= r_vga_d1.hcount;
      vga_out.vcount <= r_vga_d1.vcount;
      vga_out.hsync  <= r_vga_d1.hsync;
      vga_out.vsync  <= r_vga_d1.vsync;
      vga_out.hblnk  <= r_vga_d1.hblnk;
      vga_out.vblnk  <= r_vga_d1.vblnk;
      vga_out.rgb    <= w_rgb;
    end
  end
endmodule

// File: tb/tb_draw_player_anim.sv
// Bench for draw_player_anim: directed sprite probes plus random traffic against a frame-level model.
module tb_draw_player_anim;
  import state_pkg::*;

  localparam logic [11:0] BG = 12'h5A3;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  State        state;
  vga_if       vga_in_if ();
  vga_if       vga_out_if ();

  draw_player_anim dut (
    .clk    (clk),
    .rst    (rst),
    .vga_in (vga_in_if),
    .vga_out(vga_out_if),
    .xpos   (xpos),
    .ypos   (ypos),
    .state  (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // drive values
  logic [10:0] d_h = 11'd0, d_v = 11'd0;
  logic [11:0] d_rgb = 12'd0, d_x = 12'd0, d_y = 12'd0;
  logic [2:0]  d_ctl = 3'd0;
  logic        d_vb = 1'b0, d_rst = 1'b1;
  State        d_st = IDLE;

  // frame-level model: total frame edges, consecutive walking frame edges
  int          m_fe = 0, m_walk = 0;
  logic [11:0] m_sx = 12'd0, m_sy = 12'd0;
  logic [1:0]  m_st = 2'd0;
  logic        m_prev_vb = 1'b0;

  // expectation for the previous step's input
  logic [25:0] p_t = 26'd0;
  logic [11:0] p_rgb = 12'd0;
  logic        p_ok = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input logic [10:0] h, input logic [10:0] v,
                                            input logic [11:0] bg);
    logic [11:0] dx, dy;
    int  rx, ry;
    bit  blink, eye_l, eye_r, eye, frame1, legs;
    dx = {1'b0, h} - m_sx;
    dy = {1'b0, v} - m_sy;
    rx = int'(dx);
    ry = int'(dy);
    if (m_st == 2'd3) return bg;
    if (rx >= 40 || ry >= 80) return bg;
    blink = (m_fe % 180) >= 174;
    eye_l = ry >= 10 && ry < 16 && rx >= 6 && rx < 12;
    eye_r = ry >= 10 && ry < 16 && rx >= 28 && rx < 34;
    eye   = (m_st == 2'd0 && (eye_l || eye_r)) || (m_st == 2'd1 && eye_l) ||
            (m_st == 2'd2 && eye_r);
    if (eye && !blink) return 12'h000;
    if (ry < 60) return 12'hF00;
    frame1 = (m_st != 2'd0) && ((m_walk / 8) % 2 == 1);
    legs   = frame1 ? (rx >= 13 && rx < 27) : (rx < 13 || rx >= 27);
    return legs ? 12'hF00 : bg;
  endfunction

  task automatic step();
    logic [25:0] cur_t, e_t;
    logic [11:0] cur_rgb, e_rgb;
    logic        cur_ok, e_ok, fe;
    fe = d_vb && !m_prev_vb;
    if (d_rst) begin
      cur_t = 26'd0; cur_rgb = 12'd0; cur_ok = 1'b1;
    end else begin
      cur_t   = {d_h, d_v, d_ctl, d_vb};
      cur_rgb = model_rgb(d_h, d_v, d_rgb);
      cur_ok  = !fe;
    end
    vga_in_if.hcount = d_h;
    vga_in_if.vcount = d_v;
    vga_in_if.hsync  = d_ctl[2];
    vga_in_if.vsync  = d_ctl[1];
    vga_in_if.hblnk  = d_ctl[0];
    vga_in_if.vblnk  = d_vb;
    vga_in_if.rgb    = d_rgb;
    rst = d_rst; xpos = d_x; ypos = d_y; state = d_st;
    @(posedge clk);
    #1;
    if (d_rst) begin
      e_t = 26'd0; e_rgb = 12'd0; e_ok = 1'b1;
    end else begin
      e_t = p_t; e_rgb = p_rgb; e_ok = p_ok;
    end
    check_eq("timing", 32'({vga_out_if.hcount, vga_out_if.vcount, vga_out_if.hsync,
                           vga_out_if.vsync, vga_out_if.hblnk, vga_out_if.vblnk}), 32'(e_t));
    if (e_ok) check_eq("rgb", 32'(vga_out_if.rgb), 32'(e_rgb));
    if (d_rst) begin
      m_fe = 0; m_walk = 0; m_sx = 12'd0; m_sy = 12'd0; m_st = 2'd0; m_prev_vb = 1'b0;
    end else begin
      m_prev_vb = d_vb;
      if (fe) begin
        m_sx = d_x; m_sy = d_y; m_st = 2'(d_st); m_fe++;
        if (d_st == IDLE) m_walk = 0;
        else m_walk++;
      end
    end
    p_t = cur_t; p_rgb = cur_rgb; p_ok = cur_ok;
  endtask

  // Present one pixel, then one filler pixel, and compare the pixel's colour.
  task automatic probe(input string tag, input int h, input int v, input logic [11:0] exp);
    d_vb = 1'b0; d_h = 11'(h); d_v = 11'(v); d_rgb = BG; d_ctl = 3'b000;
    step();
    d_h = 11'd1500; d_v = 11'd1000;
    step();
    check_eq(tag, 32'(vga_out_if.rgb), 32'(exp));
  endtask

  task automatic frame_edge();
    d_h = 11'd1500; d_v = 11'd1000; d_rgb = BG;
    d_vb = 1'b0; step();
    d_vb = 1'b1; step();
    d_vb = 1'b0;
  endtask

  initial begin
    // reset with toggling inputs
    d_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_h = 11'($urandom); d_v = 11'($urandom); d_rgb = 12'($urandom);
      d_ctl = 3'($urandom); d_vb = 1'($urandom);
      step();
    end
    d_rst = 1'b0; d_vb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d_h = 11'($urandom); d_v = 11'($urandom); d_rgb = 12'($urandom); d_ctl = 3'($urandom);
      step();
    end

    // IDLE sprite at (100,300)
    d_x = 12'd100; d_y = 12'd300; d_st = IDLE;
    frame_edge();
    probe("idle_tl", 100, 300, 12'hF00);
    probe("idle_left", 99, 300, BG);
    probe("idle_below", 120, 390, BG);
    probe("idle_gap", 120, 370, BG);
    probe("idle_eye_l", 107, 311, 12'h000);
    probe("idle_eye_r", 131, 311, 12'h000);
    probe("idle_br", 139, 379, 12'hF00);
    probe("idle_right", 140, 379, BG);

    // position only moves at the frame edge
    d_x = 12'd200;
    probe("tear_old", 100, 300, 12'hF00);
    probe("tear_new_early", 200, 300, BG);
    frame_edge();
    probe("tear_new", 200, 300, 12'hF00);
    probe("tear_old_gone", 100, 300, BG);
    d_x = 12'd100;
    frame_edge();

    // walking right
    d_st = RIGHT2;
    for (int i = 0; i < 7; i++) frame_edge();
    probe("walk7_gap", 120, 370, BG);
    frame_edge();
    probe("walk8_gap", 120, 370, 12'hF00);
    probe("walk8_outer", 100, 370, BG);
    probe("right_no_eye_l", 107, 311, 12'hF00);
    probe("right_eye_r", 131, 311, 12'h000);
    for (int i = 0; i < 8; i++) frame_edge();
    probe("walk16_gap", 120, 370, BG);
    probe("walk16_outer", 100, 370, 12'hF00);
    for (int i = 0; i < 4; i++) frame_edge();
    d_st = LEFT2;
    for (int i = 0; i < 4; i++) frame_edge();
    probe("walk24_gap", 120, 370, 12'hF00);
    probe("left_eye_l", 107, 311, 12'h000);
    probe("left_no_eye_r", 131, 311, 12'hF00);
    d_st = IDLE;
    frame_edge();
    probe("back_idle_gap", 120, 370, BG);
    probe("back_idle_outer", 100, 370, 12'hF00);

    // blink cycle from reset
    d_rst = 1'b1; step(); d_rst = 1'b0;
    d_x = 12'd100; d_y = 12'd300; d_st = IDLE;
    for (int i = 0; i < 173; i++) frame_edge();
    probe("blink_173", 107, 311, 12'h000);
    for (int i = 174; i < 180; i++) begin
      frame_edge();
      probe("blink_closed", 107, 311, 12'hF00);
    end
    frame_edge();
    probe("blink_180", 107, 311, 12'h000);

    // reset in the middle of a sprite line
    d_h = 11'd110; d_v = 11'd320; d_rgb = BG; d_rst = 1'b1;
    step();
    check_eq("rst_mid", 32'(vga_out_if.rgb), 32'd0);
    d_rst = 1'b0;
    probe("post_rst_origin", 0, 0, 12'hF00);
    probe("post_rst_eye", 7, 11, 12'h000);
    probe("post_rst_outside", 45, 5, BG);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      d_rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 29) == 0) d_vb = ~d_vb;
      if ($urandom_range(0, 99) == 0) begin
        d_x  = ($urandom_range(0, 9) == 0) ? 12'(4096 - $urandom_range(1, 40))
                                           : 12'($urandom_range(0, 300));
        d_y  = 12'($urandom_range(250, 320));
        d_st = State'(2'($urandom_range(0, 3)));
      end
      d_h = 11'($urandom_range(0, 400)); d_v = 11'($urandom_range(240, 420));
      d_rgb = 12'($urandom); d_ctl = 3'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
